// File: rtl/hb2_init.sv
// Hummingbird-2 initialisation stage: loads the IV and runs four init rounds
// through one shared wd_16 evaluator, producing the initial R1..R8 state.

module wd_16 #(
   parameter int unsigned WD_LAT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [15:0] key_1,
   input  logic [15:0] key_2,
   input  logic [15:0] key_3,
   input  logic [15:0] key_4,
   input  logic [15:0] data_in,
   output logic [15:0] data_out
);
   // S-box tables, entry n held in nibble n
   localparam logic [63:0] S1_TAB = 64'h3a84_0d6b_f512_9ec7;
   localparam logic [63:0] S2_TAB = 64'h2b95_de03_c7f8_61a4;
   localparam logic [63:0] S3_TAB = 64'h79b0_438e_da65_1cf2;
   localparam logic [63:0] S4_TAB = 64'hbdc6_e03a_1279_854f;

   function automatic logic [15:0] sbox(input logic [15:0] x);
      sbox = {S4_TAB[{x[15:12], 2'b00} +: 4], S3_TAB[{x[11:8], 2'b00} +: 4],
              S2_TAB[{x[7:4], 2'b00} +: 4],   S1_TAB[{x[3:0], 2'b00} +: 4]};
   endfunction

   // f(x) = L(S(x)), L(s) = s ^ (s <<< 6) ^ (s <<< 10)
   function automatic logic [15:0] fmix(input logic [15:0] x);
      logic [15:0] s;
      s = sbox(x);
      fmix = s ^ {s[9:0], s[15:10]} ^ {s[5:0], s[15:6]};
   endfunction

   logic [15:0] res_c;

   always_comb begin
      res_c = fmix(fmix(fmix(fmix(data_in ^ key_1) ^ key_2) ^ key_3) ^ key_4);
   end

   // WD_LAT-1 register stages so data_out is valid WD_LAT cycles after data_in settles
   generate
      if (WD_LAT <= 1) begin : g_comb
         assign data_out = res_c;
      end else begin : g_pipe
         logic [15:0] pipe_q [WD_LAT-1];
         logic [15:0] pipe_d [WD_LAT-1];

         always_comb begin
            pipe_d[0] = res_c;
            for (int i = 1; i < int'(WD_LAT) - 1; i++) begin
               pipe_d[i] = pipe_q[i-1];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               for (int i = 0; i < int'(WD_LAT) - 1; i++) begin
                  pipe_q[i] <= '0;
               end
            end else begin
               pipe_q <= pipe_d;
            end
         end

         assign data_out = pipe_q[WD_LAT-2];
      end
   endgenerate
endmodule

module hb2_init #(
   parameter int unsigned WD_LAT = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [63:0]  iv,
   input  logic [127:0] key,
   output logic         busy,
   output logic         done,
   output logic [15:0]  r1_o,
   output logic [15:0]  r2_o,
   output logic [15:0]  r3_o,
   output logic [15:0]  r4_o,
   output logic [15:0]  r5_o,
   output logic [15:0]  r6_o,
   output logic [15:0]  r7_o,
   output logic [15:0]  r8_o
);
   localparam int unsigned CNT_W = (WD_LAT > 1) ? $clog2(WD_LAT) : 1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_ISSUE  = 3'd1;
   localparam logic [2:0] S_WAIT   = 3'd2;
   localparam logic [2:0] S_UPDATE = 3'd3;
   localparam logic [2:0] S_DONE   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [1:0]       round_q, round_d;
   logic [1:0]       ev_q, ev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      wd_din_q, wd_din_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [15:0]      r_q [8];
   logic [15:0]      r_d [8];
   logic [15:0]      t_q [4];
   logic [15:0]      t_d [4];
   logic [15:0]      ro_q [8];
   logic [15:0]      ro_d [8];

   logic [15:0]      sum_c [4];
   logic [15:0]      nr_c [4];
   logic [15:0]      k1_c, k2_c, k3_c, k4_c;
   logic [15:0]      wd_dout;

   // Odd evaluations use K5..K8; ev is stable through WAIT so the keys are too
   always_comb begin
      if (ev_q[0]) begin
         k1_c = key[63:48];
         k2_c = key[47:32];
         k3_c = key[31:16];
         k4_c = key[15:0];
      end else begin
         k1_c = key[127:112];
         k2_c = key[111:96];
         k3_c = key[95:80];
         k4_c = key[79:64];
      end
   end

   wd_16 #(.WD_LAT(WD_LAT)) u_wd (
      .clk      (clk),
      .rst      (~rst),
      .key_1    (k1_c),
      .key_2    (k2_c),
      .key_3    (k3_c),
      .key_4    (k4_c),
      .data_in  (wd_din_q),
      .data_out (wd_dout)
   );

   always_comb begin
      sum_c[0] = r_q[0] + t_q[3];
      sum_c[1] = r_q[1] + t_q[0];
      sum_c[2] = r_q[2] + t_q[1];
      sum_c[3] = r_q[3] + t_q[2];
   end

   always_comb begin
      nr_c[0] = {sum_c[0][12:0], sum_c[0][15:13]};
      nr_c[1] = {sum_c[1][14:0], sum_c[1][15]};
      nr_c[2] = {sum_c[2][7:0],  sum_c[2][15:8]};
      nr_c[3] = {sum_c[3][14:0], sum_c[3][15]};
   end

   always_comb begin
      state_d  = state_q;
      round_d  = round_q;
      ev_d     = ev_q;
      cnt_d    = cnt_q;
      wd_din_d = wd_din_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      r_d      = r_q;
      t_d      = t_q;
      ro_d     = ro_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               r_d[0]  = iv[63:48];
               r_d[1]  = iv[47:32];
               r_d[2]  = iv[31:16];
               r_d[3]  = iv[15:0];
               r_d[4]  = iv[63:48];
               r_d[5]  = iv[47:32];
               r_d[6]  = iv[31:16];
               r_d[7]  = iv[15:0];
               round_d = 2'd0;
               ev_d    = 2'd0;
               busy_d  = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            case (ev_q)
               2'd0:    wd_din_d = r_q[0] + 16'(round_q);
               2'd1:    wd_din_d = r_q[1] + t_q[0];
               2'd2:    wd_din_d = r_q[2] + t_q[1];
               default: wd_din_d = r_q[3] + t_q[2];
            endcase
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (cnt_q == CNT_W'(WD_LAT - 1)) begin
               t_d[ev_q] = wd_dout;
               if (ev_q != 2'd3) begin
                  ev_d    = ev_q + 2'd1;
                  state_d = S_ISSUE;
               end else begin
                  state_d = S_UPDATE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_UPDATE: begin
            for (int i = 0; i < 4; i++) begin
               r_d[i]   = nr_c[i];
               r_d[i+4] = r_q[i+4] ^ nr_c[i];
            end
            if (round_q != 2'd3) begin
               round_d = round_q + 2'd1;
               ev_d    = 2'd0;
               state_d = S_ISSUE;
            end else begin
               // Publish on entry to DONE so outputs are valid with the done pulse
               for (int i = 0; i < 4; i++) begin
                  ro_d[i]   = nr_c[i];
                  ro_d[i+4] = r_q[i+4] ^ nr_c[i];
               end
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         round_q  <= '0;
         ev_q     <= '0;
         cnt_q    <= '0;
         wd_din_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         for (int i = 0; i < 8; i++) begin
            r_q[i]  <= '0;
            ro_q[i] <= '0;
         end
         for (int i = 0; i < 4; i++) begin
            t_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         round_q  <= round_d;
         ev_q     <= ev_d;
         cnt_q    <= cnt_d;
         wd_din_q <= wd_din_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         r_q      <= r_d;
         t_q      <= t_d;
         ro_q     <= ro_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign r1_o = ro_q[0];
   assign r2_o = ro_q[1];
   assign r3_o = ro_q[2];
   assign r4_o = ro_q[3];
   assign r5_o = ro_q[4];
   assign r6_o = ro_q[5];
   assign r7_o = ro_q[6];
   assign r8_o = ro_q[7];
endmodule

// File: tb/tb_hb2_init.sv
// Bench for hb2_init: three builds (WD_LAT 1/4/7) share iv/key and are checked
// against a round-level reference model, plus abort and ignored-start sequences.

module tb_hb2_init;
   localparam logic [3:0] S1 [16] = '{4'd7, 4'd12, 4'd14, 4'd9, 4'd2, 4'd1, 4'd5, 4'd15,
                                      4'd11, 4'd6, 4'd13, 4'd0, 4'd4, 4'd8, 4'd10, 4'd3};
   localparam logic [3:0] S2 [16] = '{4'd4, 4'd10, 4'd1, 4'd6, 4'd8, 4'd15, 4'd7, 4'd12,
                                      4'd3, 4'd0, 4'd14, 4'd13, 4'd5, 4'd9, 4'd11, 4'd2};
   localparam logic [3:0] S3 [16] = '{4'd2, 4'd15, 4'd12, 4'd1, 4'd5, 4'd6, 4'd10, 4'd13,
                                      4'd14, 4'd8, 4'd3, 4'd4, 4'd0, 4'd11, 4'd9, 4'd7};
   localparam logic [3:0] S4 [16] = '{4'd15, 4'd4, 4'd5, 4'd8, 4'd9, 4'd7, 4'd2, 4'd1,
                                      4'd10, 4'd3, 4'd0, 4'd14, 4'd6, 4'd12, 4'd13, 4'd11};
   localparam int NVEC = 10;
   localparam int WINDOW = 150;

   typedef struct {
      logic [63:0]  iv;
      logic [127:0] key;
      logic [127:0] exp;
      bit           extra;
   } vec_t;

   logic         clk;
   logic         rst;
   logic [2:0]   start_v;
   logic [63:0]  iv;
   logic [127:0] key;
   logic [2:0]   busy_v;
   logic [2:0]   done_v;
   logic [15:0]  ro [3][8];

   int   n_vec;
   int   n_bad;
   vec_t vt [NVEC];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int lat_of(input int g);
      return (g == 0) ? 1 : (g == 1) ? 4 : 7;
   endfunction

   generate
      for (genvar g = 0; g < 3; g++) begin : g_dut
         hb2_init #(.WD_LAT((g == 0) ? 1 : (g == 1) ? 4 : 7)) u_dut (
            .clk   (clk),
            .rst   (rst),
            .start (start_v[g]),
            .iv    (iv),
            .key   (key),
            .busy  (busy_v[g]),
            .done  (done_v[g]),
            .r1_o  (ro[g][0]),
            .r2_o  (ro[g][1]),
            .r3_o  (ro[g][2]),
            .r4_o  (ro[g][3]),
            .r5_o  (ro[g][4]),
            .r6_o  (ro[g][5]),
            .r7_o  (ro[g][6]),
            .r8_o  (ro[g][7])
         );
      end
   endgenerate

   function automatic logic [15:0] m_rotl(input logic [15:0] x, input int n);
      logic [31:0] w;
      w = {x, x} << n;
      return w[31:16];
   endfunction

   function automatic logic [15:0] m_f(input logic [15:0] x);
      logic [15:0] s;
      s = {S4[x[15:12]], S3[x[11:8]], S2[x[7:4]], S1[x[3:0]]};
      return s ^ m_rotl(s, 6) ^ m_rotl(s, 10);
   endfunction

   function automatic logic [15:0] m_wd16(input logic [15:0] x, input logic [63:0] ks);
      logic [15:0] y;
      y = x;
      for (int j = 0; j < 4; j++) y = m_f(y ^ ks[63-16*j -: 16]);
      return y;
   endfunction

   // Reference: four rounds of four WD16 evaluations, then the R update
   function automatic logic [127:0] model(input logic [63:0] v_iv, input logic [127:0] v_key);
      logic [15:0]  r [8];
      logic [15:0]  t [4];
      logic [15:0]  nr [4];
      logic [15:0]  d;
      logic [127:0] pk;
      for (int i = 0; i < 8; i++) r[i] = v_iv[63-16*(i%4) -: 16];
      for (int i = 0; i < 4; i++) t[i] = '0;
      for (int rnd = 0; rnd < 4; rnd++) begin
         for (int e = 0; e < 4; e++) begin
            if (e == 0) d = 16'(r[0] + 16'(rnd));
            else        d = 16'(r[e] + t[e-1]);
            t[e] = m_wd16(d, (e % 2 == 0) ? v_key[127:64] : v_key[63:0]);
         end
         nr[0] = m_rotl(16'(r[0] + t[3]), 3);
         nr[1] = m_rotl(16'(r[1] + t[0]), 1);
         nr[2] = m_rotl(16'(r[2] + t[1]), 8);
         nr[3] = m_rotl(16'(r[3] + t[2]), 1);
         for (int i = 0; i < 4; i++) begin
            r[i]   = nr[i];
            r[i+4] = r[i+4] ^ nr[i];
         end
      end
      pk = '0;
      for (int i = 0; i < 8; i++) pk = {pk[111:0], r[i]};
      return pk;
   endfunction

   function automatic logic [127:0] r_packed(input int g);
      logic [127:0] pk;
      pk = '0;
      for (int i = 0; i < 8; i++) pk = {pk[111:0], ro[g][i]};
      return pk;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // One run on all three builds; extra=1 adds ignored starts to the WD_LAT=4 build
   task automatic run_vec(input int idx, input logic [63:0] v_iv, input logic [127:0] v_key,
                          input logic [127:0] exp, input bit extra);
      int first [3];
      int pulses [3];
      for (int g = 0; g < 3; g++) begin
         first[g]  = 0;
         pulses[g] = 0;
      end
      @(negedge clk);
      iv      = v_iv;
      key     = v_key;
      start_v = 3'b111;
      @(negedge clk);
      start_v = 3'b000;
      chk($sformatf("v%0d_busy_after_accept", idx), 128'(busy_v), 128'(3'b111));
      for (int cyc = 1; cyc <= WINDOW; cyc++) begin
         for (int g = 0; g < 3; g++) begin
            if (done_v[g]) begin
               pulses[g]++;
               if (first[g] == 0) first[g] = cyc;
            end
         end
         start_v = (extra && (cyc == 10 || cyc == 85)) ? 3'b010 : 3'b000;
         @(negedge clk);
      end
      start_v = 3'b000;
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("v%0d_latency_L%0d", idx, lat_of(g)), 128'(first[g]),
             128'(4 * (4 * (lat_of(g) + 1) + 1) + 1));
         chk($sformatf("v%0d_pulses_L%0d", idx, lat_of(g)), 128'(pulses[g]), 128'(1));
         chk($sformatf("v%0d_r_L%0d", idx, lat_of(g)), r_packed(g), exp);
      end
      chk($sformatf("v%0d_idle_busy", idx), 128'(busy_v), 128'(0));
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int pulses;
      int busy_seen;
      rst     = 1'b0;
      start_v = 3'b000;
      iv      = '0;
      key     = '0;
      n_vec   = 0;
      n_bad   = 0;

      vt[0] = '{iv: 64'h0, key: 128'h0, exp: '0, extra: 1'b0};
      vt[1] = '{iv: 64'h0123_4567_89AB_CDEF,
                key: 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, exp: '0, extra: 1'b0};
      vt[2] = vt[1];
      vt[2].extra = 1'b1;
      vt[3] = '{iv: 64'hFFFF_FFFF_FFFF_FFFF, key: {128{1'b1}}, exp: '0, extra: 1'b0};
      for (int i = 4; i < NVEC; i++) begin
         vt[i].iv    = {$urandom, $urandom};
         vt[i].key   = {$urandom, $urandom, $urandom, $urandom};
         vt[i].extra = 1'b0;
      end
      for (int i = 0; i < NVEC; i++) vt[i].exp = model(vt[i].iv, vt[i].key);

      repeat (3) @(negedge clk);
      chk("reset_busy", 128'(busy_v), 128'(0));
      chk("reset_done", 128'(done_v), 128'(0));
      for (int g = 0; g < 3; g++) chk($sformatf("reset_r_L%0d", lat_of(g)), r_packed(g), '0);
      rst = 1'b1;

      for (int i = 0; i < NVEC; i++) run_vec(i, vt[i].iv, vt[i].key, vt[i].exp, vt[i].extra);

      // Abort 30 cycles into a run: outputs clear at once, nothing follows without a new start
      @(negedge clk);
      iv      = vt[1].iv;
      key     = vt[1].key;
      start_v = 3'b111;
      @(negedge clk);
      start_v = 3'b000;
      repeat (29) @(negedge clk);
      rst = 1'b0;
      #1;
      chk("abort_busy", 128'(busy_v), 128'(0));
      chk("abort_done", 128'(done_v), 128'(0));
      for (int g = 0; g < 3; g++) chk($sformatf("abort_r_L%0d", lat_of(g)), r_packed(g), '0);
      @(negedge clk);
      rst       = 1'b1;
      pulses    = 0;
      busy_seen = 0;
      for (int cyc = 0; cyc < 160; cyc++) begin
         @(negedge clk);
         if (done_v != 3'b000) pulses++;
         if (busy_v != 3'b000) busy_seen++;
      end
      chk("post_abort_done", 128'(pulses), 128'(0));
      chk("post_abort_busy", 128'(busy_seen), 128'(0));
      chk("post_abort_r_L4", r_packed(1), '0);

      run_vec(NVEC, vt[1].iv, vt[1].key, vt[1].exp, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
